// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
// Multiplexed seven-segment display controller on the Minisys-1A I/O bus.
// Holds up to 8 hex digits with per-digit blank, decimal point and blink
// control. Scans one digit per slot, and each slot starts with a dark
// interval to suppress ghosting. All timing comes from the system clock.
//
// Ports:
//   clock          system clock, rising edge
//   reset          asynchronous, active-high
//   Select         chip select from the address decoder
//   Write_enable   write strobe, qualified by Select
//   Address[2:0]   register byte address (0 DATA_LO, 2 DATA_HI, 4 MASK, 6 CTRL)
//   Write_data_in  write data
//   Read_data_out  combinational register readback
//   Enable[7:0]    digit anodes, active low, registered
//   Value[7:0]     {DP, CG..CA}, active low, registered
module display_scan_ctrl #(
    parameter int DIGITS       = 8,
    parameter int SCAN_DIV     = 2048,
    parameter int BLANK_CYCLES = 256,
    parameter int BLINK_DIV    = 4_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        Select,
    input  logic        Write_enable,
    input  logic [2:0]  Address,
    input  logic [15:0] Write_data_in,
    output logic [15:0] Read_data_out,
    output logic [7:0]  Enable,
    output logic [7:0]  Value
);

    localparam int SLOT_W  = $clog2(SCAN_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV);

    // Anode bits for unpopulated digits are forced high.
    localparam logic [8:0] POP9 = (9'd1 << DIGITS) - 9'd1;
    localparam logic [7:0] POP  = POP9[7:0];

    logic [15:0]        data_lo;
    logic [15:0]        data_hi;
    logic [15:0]        mask;
    logic [8:0]         ctrl;
    logic [SLOT_W-1:0]  slot_cnt;
    logic [2:0]         idx;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;

    logic               wr_en;
    logic               ctrl_wr;
    logic [31:0]        digits;
    logic [3:0]         nib;
    logic [7:0]         blank_bits;
    logic [7:0]         blink_sel;
    logic               dp_on;
    logic               lit;
    logic [7:0]         enable_d;
    logic [7:0]         value_d;

    function automatic logic [6:0] seg(input logic [3:0] h);
        case (h)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
    endfunction

    // Odd addresses are unmapped; all even addresses hit a register.
    assign wr_en   = Select & Write_enable & ~Address[0];
    assign ctrl_wr = wr_en & (Address[2:1] == 2'd3);

    // Readback
    always_comb begin
        Read_data_out = 16'h0000;
        if (Select && !Write_enable) begin
            case (Address)
                3'd0:    Read_data_out = data_lo;
                3'd2:    Read_data_out = data_hi;
                3'd4:    Read_data_out = mask;
                3'd6:    Read_data_out = {7'd0, ctrl};
                default: Read_data_out = 16'h0000;
            endcase
        end
    end

    // Next output values are derived from the current scan position, so the
    // first edge after reset shows slot 0 (dark) of digit 0.
    assign digits     = {data_hi, data_lo};
    assign nib        = digits[{idx, 2'b00} +: 4];
    assign blank_bits = mask[7:0];
    assign blink_sel  = ctrl[7:0];
    assign dp_on      = mask[{1'b1, idx}];

    assign lit = (slot_cnt >= SLOT_W'(BLANK_CYCLES)) && ctrl[8] &&
                 !blank_bits[idx] && !(blink_sel[idx] && blink_phase);

    assign enable_d = (lit ? ~(8'd1 << idx) : 8'hFF) | ~POP;
    assign value_d  = {~dp_on, seg(nib)};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_lo     <= 16'h0000;
            data_hi     <= 16'h0000;
            mask        <= 16'h0000;
            ctrl        <= 9'h100;
            slot_cnt    <= '0;
            idx         <= 3'd0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            Enable      <= 8'hFF;
            Value       <= 8'hFF;
        end else begin
            if (wr_en) begin
                case (Address[2:1])
                    2'd0:    data_lo <= Write_data_in;
                    2'd1:    data_hi <= Write_data_in;
                    2'd2:    mask    <= Write_data_in;
                    default: ctrl    <= Write_data_in[8:0];
                endcase
            end

            // Scan position keeps running even when scan is disabled.
            if (slot_cnt == SLOT_W'(SCAN_DIV - 1)) begin
                slot_cnt <= '0;
                idx      <= (idx == 3'(DIGITS - 1)) ? 3'd0 : idx + 3'd1;
            end else begin
                slot_cnt <= slot_cnt + 1'b1;
            end

            // Any CTRL write restarts blink in the visible phase so newly
            // selected digits are seen immediately.
            if (ctrl_wr) begin
                blink_cnt   <= '0;
                blink_phase <= 1'b0;
            end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end

            Enable <= enable_d;
            Value  <= value_d;
        end
    end

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Parametrised multiplexed seven-segment display controller on the Minisys-1A I/O bus, successor to the fixed 8-digit display port. It holds up to 8 hex digits, per-digit blank, decimal-point and blink control, and register readback. It scans one digit per slot and inserts an anti-ghosting blank interval between slots. All scan timing runs from the single system clock with internal dividers; there are no derived clocks.

## Interface
- DIGITS, 8: number of populated digits, 1..8. Enable bits at or above DIGITS are always driven high (off).
- SCAN_DIV, 2048: clock cycles per digit slot, ≥ 4.
- BLANK_CYCLES, 256: cycles at the start of each slot with all digits off, 1..SCAN_DIV-1.
- BLINK_DIV, 4_000_000: clock cycles per blink half-period, ≥ 2.
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- Select  in  1  chip select from the address decoder.
- Write_enable  in  1  bus write strobe, qualified by Select.
- Address  in  3  register byte address: 0, 2, 4 or 6.
- Write_data_in  in  16  write data.
- Read_data_out  out  16  read data, combinational from the registers.
- Enable  out  8  digit anodes A0-A7, active low.
- Value  out  8  segments CA-CG in bits [6:0] and DP in bit [7], active low.

## Operation
- Registers:
  - 0 DATA_LO: digits 0-3, 4 bits each, digit 0 in bits [3:0].
  - 2 DATA_HI: digits 4-7.
  - 4 MASK: bits [7:0] blank, 1 = digit off; bits [15:8] DP, 1 = DP lit.
  - 6 CTRL: bits [7:0] blink select; bit 8 scan enable; bits [15:9] read as 0.
- Reset values: DATA 0, MASK 0, CTRL 0x0100 (scan on, no blink).
- Write: when Select=1 and Write_enable=1, the register at Address loads the full 16 bits. Writes to odd or unmapped addresses are ignored.
- Read: when Select=1 and Write_enable=0, Read_data_out shows the register at Address. Unmapped addresses and Select=0 return 0x0000.
- Select=0 only blocks bus access. Register contents and scanning are unaffected.
- Scan counters:
  - slot counter runs 0..SCAN_DIV-1.
  - digit index runs 0..DIGITS-1 and advances when the slot counter wraps; it wraps from DIGITS-1 to 0.
- Per slot:
  - while slot counter < BLANK_CYCLES: Enable = 0xFF.
  - otherwise Enable = ~(1 << idx), unless the digit is suppressed, in which case Enable = 0xFF.
  - A digit is suppressed when any of these hold: scan enable = 0, MASK blank bit set, or blink select bit set while blink phase = 1.
- Value = {~DP[idx], seg(nibble[idx])}. Value is driven even during blank intervals.
- seg decode, bits [6:0] active low, hex 0-F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E, masked to 7 bits.
- Blink: a free-running counter toggles blink phase every BLINK_DIV cycles. Any CTRL write clears the blink counter and sets phase to 0 (digits visible).
- Clearing scan enable leaves the counters running and only forces Enable to 0xFF.

## Timing
- Enable and Value are registered. Inputs sampled at edge N appear on the outputs after edge N+1.
- A register write at edge N affects the outputs from edge N+1.
- Slot length is exactly SCAN_DIV cycles, with exactly BLANK_CYCLES of them dark.
- Frame period is DIGITS × SCAN_DIV cycles.
- Reset asserted at any time, including mid-slot or mid-write: Enable = 0xFF and Value = 0xFF immediately. All counters, the digit index and blink phase go to 0, and registers take their reset values.
- After reset is released, the first edge starts the blank interval of digit 0.
- DIGITS=1: the index stays at 0 and slots still contain the blank interval.

## Test plan
Parameters for all tests: DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2, BLINK_DIV=64.
- Reset and decode: assert reset, write DATA_LO=0x3210, release → Enable=0xFF for 3 cycles then 0xFE with Value=0xC0; the next slot shows Enable=0xFD with Value=0xF9, then digits 2 and 3; wrap back to digit 0 after 32 cycles.
- Blank and DP: MASK=0x0102 → digit 1 slot holds Enable=0xFF for all 8 cycles; digit 0 shows Value=0x40.
- Blink: CTRL=0x0101 → digit 0 lit for 64 cycles, dark for 64, lit again; other digits never blink.
- Readback and unmapped access: write 0xBEEF to address 2 then read → 0xBEEF; write to address 5 → no register changes; read with Select=0 → 0x0000; counters unaffected by Select toggling.
- Scan disable and reset mid-operation: CTRL=0x0000 → Enable stays 0xFF. Set CTRL=0x0100 and assert reset mid-slot → outputs go to 0xFF without waiting for a clock edge; after release the scan restarts at digit 0.
